route_sched: RTL and testbench



---
 rtl/route_pkg.sv | 22 ++
 rtl/wp_fifo.sv | 60 ++++++
 rtl/route_sched.sv | 136 +++++++++++++
 tb/tb_route_sched.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/route_pkg.sv
// Shared types and constants for the waypoint route scheduler.
package route_pkg;

  typedef enum logic [1:0] {
    STOP  = 2'b00,
    GO    = 2'b01,
    ADD   = 2'b10,
    START = 2'b11
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    TRANSIT,
    DWELL
  } sched_state_t;

  localparam logic [7:0] CMD_STOP = 8'h00;
  localparam logic [1:0] OP_GO    = 2'b01;
  localparam int         ID_W     = 6;

endpackage

// File: rtl/wp_fifo.sv
// Waypoint ID FIFO: first-word-fall-through read, flush clears pointers and count.
module wp_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO is still accepted.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/route_sched.sv
// Waypoint scheduler: queues destination IDs and dispatches them as GO commands,
// waiting for arrival and a dwell period between stops; STOP/GO bypass and abort.
module route_sched
  import route_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int DWELL_CYCLES = 25000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rx_cmd,
  input  logic                   rx_rdy,
  output logic                   clr_rx_rdy,
  output logic [7:0]             cmd,
  output logic                   cmd_rdy,
  input  logic                   clr_cmd_rdy,
  input  logic                   in_transit,
  output logic                   route_active,
  output logic [$clog2(DEPTH):0] q_cnt,
  output logic                   q_ovfl,
  output logic                   route_done
);

  localparam int             DW         = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DW-1:0]  DWELL_LAST = DW'(DWELL_CYCLES - 1);

  sched_state_t    state, state_next;
  opcode_t         op;
  logic            first;
  logic [DW-1:0]   dwell_cnt;
  logic            push, pop, flush, load, done_set;
  logic [7:0]      load_val;
  logic [ID_W-1:0] head;
  logic            fifo_full, fifo_empty;

  assign op           = opcode_t'(rx_cmd[7:6]);
  assign clr_rx_rdy   = rx_rdy;
  assign route_active = (state != IDLE);

  wp_fifo #(.DEPTH(DEPTH), .WIDTH(ID_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (rx_cmd[ID_W-1:0]),
    .rdata (head),
    .count (q_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      first <= 1'b0;
    end else begin
      state <= state_next;
      first <= (state_next != state);
    end
  end

  // NOTE: every output of this block is given a default first so no latch can be inferred.
  always_comb begin
    state_next = state;
    push       = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;
    load       = 1'b0;
    load_val   = cmd;
    done_set   = 1'b0;

    unique case (state)
      IDLE:    if (rx_rdy && op == START && !fifo_empty) state_next = ISSUE;
      ISSUE: begin
        if (first) begin
          pop      = 1'b1;
          load     = 1'b1;
          load_val = {OP_GO, head};
        end else if (clr_cmd_rdy) begin
          state_next = TRANSIT;
        end
      end
      // in_transit only rises the cycle after acceptance, so the entry cycle is skipped.
      TRANSIT: begin
        if (!first && !in_transit) begin
          if (fifo_empty) begin
            done_set   = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = DWELL;
          end
        end
      end
      DWELL:   if (dwell_cnt == DWELL_LAST) state_next = ISSUE;
      default: state_next = IDLE;
    endcase

    // Immediate commands override whatever the route was doing this cycle.
    if (rx_rdy) begin
      unique case (op)
        STOP, GO: begin
          flush      = 1'b1;
          pop        = 1'b0;
          done_set   = 1'b0;
          load       = 1'b1;
          load_val   = (op == STOP) ? CMD_STOP : rx_cmd;
          state_next = IDLE;
        end
        ADD:     push = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_cnt  <= '0;
      cmd        <= CMD_STOP;
      cmd_rdy    <= 1'b0;
      q_ovfl     <= 1'b0;
      route_done <= 1'b0;
    end else begin
      dwell_cnt  <= (state == DWELL) ? dwell_cnt + 1'b1 : '0;
      q_ovfl     <= push && fifo_full && !pop;
      route_done <= done_set;
      if (load) begin
        cmd     <= load_val;
        cmd_rdy <= 1'b1;
      end else if (clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_route_sched.sv
// Self-checking bench for route_sched: directed scenarios plus random traffic,
// scored against a queue-based reference model of the scheduler.
module tb_route_sched;

  localparam int DEPTH = 8;
  localparam int DWELL = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_cmd;
  logic       rx_rdy;
  logic       clr_rx_rdy;
  logic [7:0] cmd;
  logic       cmd_rdy;
  logic       clr_cmd_rdy;
  logic       in_transit;
  logic       route_active;
  logic [3:0] q_cnt;
  logic       q_ovfl;
  logic       route_done;

  route_sched #(.DEPTH(DEPTH), .DWELL_CYCLES(DWELL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_cmd       (rx_cmd),
    .rx_rdy       (rx_rdy),
    .clr_rx_rdy   (clr_rx_rdy),
    .cmd          (cmd),
    .cmd_rdy      (cmd_rdy),
    .clr_cmd_rdy  (clr_cmd_rdy),
    .in_transit   (in_transit),
    .route_active (route_active),
    .q_cnt        (q_cnt),
    .q_ovfl       (q_ovfl),
    .route_done   (route_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: waypoint list as a queue, route progress as a phase plus countdown.
  typedef enum {M_IDLE, M_LOAD, M_WAIT, M_SKIP, M_ARRIVE, M_DWELL} mphase_t;

  typedef struct packed {
    logic [7:0] cmd;
    logic       cmd_rdy;
    logic       active;
    logic [3:0] q_cnt;
    logic       ovfl;
    logic       done;
    logic       clr_rx;
  } snap_t;

  logic [5:0] m_q[$];
  mphase_t    m_ph;
  int         m_left;
  logic [7:0] m_cmd;
  logic       m_rdy;
  logic       m_ovfl;
  logic       m_done;
  snap_t      exp_q[$];

  task automatic model_reset();
    m_q.delete();
    m_ph   = M_IDLE;
    m_left = 0;
    m_cmd  = 8'h00;
    m_rdy  = 1'b0;
    m_ovfl = 1'b0;
    m_done = 1'b0;
  endtask

  task automatic push_snap();
    exp_q.push_back('{cmd: m_cmd, cmd_rdy: m_rdy, active: (m_ph != M_IDLE),
                      q_cnt: 4'(m_q.size()), ovfl: m_ovfl, done: m_done, clr_rx: rx_rdy});
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_step();
    logic [1:0] op;
    logic [5:0] id;
    logic       load;
    op     = rx_cmd[7:6];
    load   = 1'b0;
    m_ovfl = 1'b0;
    m_done = 1'b0;
    case (m_ph)
      M_IDLE:   if (rx_rdy && op == 2'b11 && m_q.size() != 0) m_ph = M_LOAD;
      M_LOAD: begin
        if (m_q.size() != 0) begin
          id    = m_q.pop_front();
          m_cmd = {2'b01, id};
          load  = 1'b1;
        end
        m_ph = M_WAIT;
      end
      M_WAIT:   if (clr_cmd_rdy) m_ph = M_SKIP;
      M_SKIP:   m_ph = M_ARRIVE;
      M_ARRIVE: begin
        if (!in_transit) begin
          if (m_q.size() == 0) begin
            m_done = 1'b1;
            m_ph   = M_IDLE;
          end else begin
            m_ph   = M_DWELL;
            m_left = DWELL;
          end
        end
      end
      M_DWELL: begin
        m_left--;
        if (m_left == 0) m_ph = M_LOAD;
      end
      default: m_ph = M_IDLE;
    endcase
    if (rx_rdy) begin
      case (op)
        2'b00, 2'b01: begin
          m_q.delete();
          m_cmd  = (op == 2'b00) ? 8'h00 : rx_cmd;
          load   = 1'b1;
          m_ph   = M_IDLE;
          m_done = 1'b0;
        end
        2'b10: begin
          if (m_q.size() < DEPTH) m_q.push_back(rx_cmd[5:0]);
          else m_ovfl = 1'b1;
        end
        default: ;
      endcase
    end
    if (load) m_rdy = 1'b1;
    else if (clr_cmd_rdy) m_rdy = 1'b0;
    push_snap();
  endtask

  task automatic cyc(input logic rdy, input logic [7:0] b, input logic clr, input logic it);
    @(negedge clk);
    rst_n       = 1'b1;
    rx_rdy      = rdy;
    rx_cmd      = b;
    clr_cmd_rdy = clr;
    in_transit  = it;
    model_step();
  endtask

  task automatic idle();
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_cyc();
    @(negedge clk);
    rst_n       = 1'b0;
    rx_rdy      = 1'b0;
    rx_cmd      = 8'h00;
    clr_cmd_rdy = 1'b0;
    in_transit  = 1'b0;
    model_reset();
    push_snap();
    #1;
    check("rst_cmd",     cmd,          0);
    check("rst_cmd_rdy", cmd_rdy,      0);
    check("rst_active",  route_active, 0);
    check("rst_q_cnt",   q_cnt,        0);
    check("rst_ovfl",    q_ovfl,       0);
    check("rst_done",    route_done,   0);
  endtask

  // Monitor: compares every cycle's outputs against the oldest expected snapshot.
  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_cmd",        cmd,          e.cmd);
        check("sb_cmd_rdy",    cmd_rdy,      e.cmd_rdy);
        check("sb_active",     route_active, e.active);
        check("sb_q_cnt",      q_cnt,        e.q_cnt);
        check("sb_q_ovfl",     q_ovfl,       e.ovfl);
        check("sb_route_done", route_done,   e.done);
        check("sb_clr_rx_rdy", clr_rx_rdy,   e.clr_rx);
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    rx_rdy      = 1'b0;
    rx_cmd      = 8'h00;
    clr_cmd_rdy = 1'b0;
    in_transit  = 1'b0;
    model_reset();
    reset_cyc();
    idle();

    // Two-waypoint route with dwell timing.
    cyc(1'b1, 8'h85, 1'b0, 1'b0);
    cyc(1'b1, 8'h8A, 1'b0, 1'b0);
    cyc(1'b1, 8'hC0, 1'b0, 1'b0);
    idle(); settle();
    check("first_dispatch", cmd,     8'h45);
    check("first_rdy",      cmd_rdy, 1);
    check("q_after_pop",    q_cnt,   1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (4) idle();
    settle();
    check("dwell_not_early", cmd_rdy, 0);
    idle(); settle();
    check("second_dispatch", cmd,     8'h4A);
    check("second_rdy",      cmd_rdy, 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    settle();
    check("route_done",  route_done,   1);
    check("done_q_cnt",  q_cnt,        0);
    check("done_idle",   route_active, 0);
    idle(); settle();
    check("done_one_pulse", route_done, 0);

    // Overflow on the ninth ADD, then ADD during a pop with a full queue.
    for (int k = 1; k <= 9; k++) cyc(1'b1, {2'b10, 6'(k)}, 1'b0, 1'b0);
    settle();
    check("ovfl_pulse", q_ovfl, 1);
    check("ovfl_q_cnt", q_cnt,  8);
    idle(); settle();
    check("ovfl_one_pulse", q_ovfl, 0);
    cyc(1'b1, 8'hC0, 1'b0, 1'b0);
    cyc(1'b1, 8'hBF, 1'b0, 1'b0);
    settle();
    check("full_add_pop_cnt", q_cnt, 8);
    check("third_dispatch",   cmd,   8'h41);

    // GO overwrites an unaccepted dispatch and aborts the route.
    cyc(1'b1, 8'h53, 1'b0, 1'b0);
    settle();
    check("go_cmd",    cmd,          8'h53);
    check("go_rdy",    cmd_rdy,      1);
    check("go_idle",   route_active, 0);
    check("go_flush",  q_cnt,        0);

    // STOP while in transit with three waypoints left.
    for (int k = 0; k < 4; k++) cyc(1'b1, {2'b10, 6'(k + 20)}, 1'b0, 1'b0);
    cyc(1'b1, 8'hC0, 1'b0, 1'b0);
    idle();
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 8'h00, 1'b0, 1'b1);
    settle();
    check("stop_cmd",     cmd,          8'h00);
    check("stop_rdy",     cmd_rdy,      1);
    check("stop_q_cnt",   q_cnt,        0);
    check("stop_idle",    route_active, 0);
    check("stop_no_done", route_done,   0);

    // START with an empty queue does nothing.
    idle();
    cyc(1'b1, 8'hC0, 1'b0, 1'b0);
    idle(); settle();
    check("start_empty_idle", route_active, 0);
    check("start_empty_rdy",  cmd_rdy,      1);

    // Reset while dwelling, then START on the emptied queue.
    cyc(1'b1, 8'h81, 1'b0, 1'b0);
    cyc(1'b1, 8'h82, 1'b0, 1'b0);
    cyc(1'b1, 8'hC0, 1'b0, 1'b0);
    idle();
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    idle();
    reset_cyc();
    idle();
    cyc(1'b1, 8'hC0, 1'b0, 1'b0);
    idle(); idle(); settle();
    check("post_rst_start_active", route_active, 0);
    check("post_rst_start_rdy",    cmd_rdy,      0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int         r;
      logic       rdy;
      logic [5:0] id;
      logic [7:0] b;
      if ($urandom_range(999) == 0) begin
        reset_cyc();
      end else begin
        rdy = ($urandom_range(99) < 30);
        r   = $urandom_range(99);
        id  = 6'($urandom_range(63));
        if (r < 50)      b = {2'b10, id};
        else if (r < 85) b = {2'b11, id};
        else if (r < 93) b = {2'b01, id};
        else             b = {2'b00, id};
        cyc(rdy, b, 1'($urandom_range(1)), 1'($urandom_range(1)));
      end
    end

    repeat (2) @(posedge clk);
    #3;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
